// File: rtl/mips_defs.sv
// Shared MIPS definitions: R-type funct codes, mul/div FSM states, ALUOp constants.
// Used by the EX-stage ALU and the multiply/divide unit.
package mips_defs;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_t;

  localparam logic [2:0] ALUOP_ADD   = 3'd0;
  localparam logic [2:0] ALUOP_SUB   = 3'd1;
  localparam logic [2:0] ALUOP_AND   = 3'd2;
  localparam logic [2:0] ALUOP_OR    = 3'd3;
  localparam logic [2:0] ALUOP_SLT   = 3'd4;
  localparam logic [2:0] ALUOP_RTYPE = 3'd7;

  function automatic logic is_muldiv(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
           (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Mul/div datapath: shift-add multiply, restoring divide, sign fix-up on the outputs.
// One radix-2 step per step_i; MULDIV_FAST_MUL_EN loads the full product on load_i instead.
// No flow control; the FSM in muldiv_unit sequences load/step.
import mips_defs::*;

module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic               div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d, bz_q, bz_d;

  logic               sa, sb, ge;
  logic [WIDTH-1:0]   ma, mb, diff, quo, rem;
  logic [WIDTH:0]     t, sum;
  logic [2*WIDTH-1:0] prod;

  assign sa = is_signed_i & a_i[WIDTH-1];
  assign sb = is_signed_i & b_i[WIDTH-1];
  assign ma = sa ? -a_i : a_i;
  assign mb = sb ? -b_i : b_i;

  always_comb begin
    acc_d  = acc_q;
    opd_d  = opd_q;
    div_d  = div_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    bz_d   = bz_q;
    t      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge     = t >= {1'b0, opd_q};
    diff   = t[WIDTH-1:0] - opd_q;
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    if (load_i) begin
      div_d  = is_div_i;
      qneg_d = sa ^ sb;
      rneg_d = sa;
      bz_d   = (b_i == '0);
      opd_d  = is_div_i ? mb : ma;
      acc_d  = {{WIDTH{1'b0}}, (is_div_i ? ma : mb)};
`ifdef MULDIV_FAST_MUL_EN
      if (!is_div_i) acc_d = {{WIDTH{1'b0}}, ma} * {{WIDTH{1'b0}}, mb};
`endif
    end else if (step_i) begin
      if (div_q) acc_d = {(ge ? diff : t[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
      else       acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  // With a zero divisor the remainder ends as |dividend|, so the sign fix returns the raw dividend.
  always_comb begin
    prod = qneg_q ? -acc_q : acc_q;
    quo  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    hi_o = div_q ? rem : prod[2*WIDTH-1:WIDTH];
    lo_o = div_q ? (bz_q ? '1 : quo) : prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opd_q  <= '0;
      div_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      bz_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opd_q  <= opd_d;
      div_q  <= div_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      bz_q   <= bz_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage HI/LO owner and mul/div sequencer (IDLE -> RUN -> FIX); MULDIV_FAST_MUL_EN skips RUN for multiplies.
// Mul/div: DoneE at N+WIDTH+1 (N+1 fast mul); MFHI/MFLO combinational, MTHI/MTLO one edge.
// BusyE stalls the hazard unit while not IDLE; starts seen while busy are ignored.
import mips_defs::*;

module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StartE,
  input  logic [5:0]       FunctE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             CancelE,
  output logic             BusyE,
  output logic [WIDTH-1:0] MdResultE,
  output logic             DoneE
);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, core_hi, core_lo;
  logic             go, step, done, is_md, is_div, is_signed;

  assign is_md     = is_muldiv(FunctE);
  assign is_div    = (FunctE == FUNCT_DIV) || (FunctE == FUNCT_DIVU);
  assign is_signed = (FunctE == FUNCT_MULT) || (FunctE == FUNCT_DIV);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    go      = 1'b0;
    step    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (StartE && !CancelE) begin
          if (FunctE == FUNCT_MTHI) hi_d = SrcAE;
          if (FunctE == FUNCT_MTLO) lo_d = SrcAE;
          if (is_md) begin
            go    = 1'b1;
            cnt_d = CNT_W'(WIDTH);
`ifdef MULDIV_FAST_MUL_EN
            state_d = is_div ? S_RUN : S_FIX;
`else
            state_d = S_RUN;
`endif
          end
        end
      end
      S_RUN: begin
        if (CancelE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        // A flush landing on the write-back cycle still suppresses the update.
        if (!CancelE) begin
          hi_d = core_hi;
          lo_d = core_lo;
          done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Any muldiv-class issue while busy is already covered by the non-IDLE term.
  assign BusyE = (state_q != S_IDLE);
  assign DoneE = done;

  always_comb begin
    MdResultE = '0;
    if (state_q == S_IDLE && StartE) begin
      if (FunctE == FUNCT_MFHI)      MdResultE = hi_q;
      else if (FunctE == FUNCT_MFLO) MdResultE = lo_q;
    end
  end

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (go),
    .step_i      (step),
    .is_div_i    (is_div),
    .is_signed_i (is_signed),
    .a_i         (SrcAE),
    .b_i         (SrcBE),
    .hi_o        (core_hi),
    .lo_o        (core_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vectors with literal results plus randomized traffic against an arithmetic model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [5:0] F_MFHI  = 6'h10, F_MTHI  = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1A, F_DIVU = 6'h1B;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0, rst_n = 1'b0, StartE = 1'b0, CancelE = 1'b0;
  logic [5:0]   FunctE = '0;
  logic [W-1:0] SrcAE = '0, SrcBE = '0;
  logic         BusyE, DoneE;
  logic [W-1:0] MdResultE;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StartE    (StartE),
    .FunctE    (FunctE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .CancelE   (CancelE),
    .BusyE     (BusyE),
    .MdResultE (MdResultE),
    .DoneE     (DoneE)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Architectural result of a mul/div, straight from 64-bit integer arithmetic.
  function automatic void ref_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (f)
      F_MULT:  p = sa * sb;
      F_MULTU: p = {32'b0, a} * {32'b0, b};
      F_DIV: begin
        if (b == '0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      F_DIVU: p = (b == '0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: p = '0;
    endcase
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  function automatic bit is_mul(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU);
  endfunction

  // Model: HI/LO, pending result and number of busy cycles still ahead.
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int busy_left = 0;

  always @(negedge clk) begin : cmp
    logic [W-1:0] e_md;
    logic e_busy, e_done;
    if (!rst_n) begin
      m_hi = '0;
      m_lo = '0;
      busy_left = 0;
    end
    e_busy = (busy_left > 0);
    e_done = (busy_left == 1) && !CancelE && rst_n;
    e_md   = '0;
    if (!e_busy && StartE && FunctE == F_MFHI) e_md = m_hi;
    if (!e_busy && StartE && FunctE == F_MFLO) e_md = m_lo;
    chk("BusyE", {31'b0, BusyE}, {31'b0, e_busy});
    chk("DoneE", {31'b0, DoneE}, {31'b0, e_done});
    chk("MdResultE", MdResultE, e_md);
    if (rst_n) begin
      if (busy_left > 0) begin
        if (CancelE) busy_left = 0;
        else begin
          busy_left--;
          if (busy_left == 0) begin
            m_hi = p_hi;
            m_lo = p_lo;
          end
        end
      end else if (StartE && !CancelE) begin
        case (FunctE)
          F_MTHI: m_hi = SrcAE;
          F_MTLO: m_lo = SrcAE;
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            ref_op(FunctE, SrcAE, SrcBE, p_hi, p_lo);
            busy_left = (FAST && is_mul(FunctE)) ? 1 : W + 1;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic drive(input logic s, input logic [5:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c);
    @(posedge clk);
    #1;
    StartE = s; FunctE = f; SrcAE = a; SrcBE = b; CancelE = c;
  endtask

  task automatic idle();
    drive(1'b0, 6'h0, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [5:0] f, input logic [W-1:0] exp, input string nm);
    drive(1'b1, f, '0, '0, 1'b0);
    @(negedge clk);
    chk(nm, MdResultE, exp);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      idle();
      @(negedge clk);
      if (!BusyE) return;
    end
    chk("wait_idle_timeout", {31'b0, BusyE}, '0);
  endtask

  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input string nm);
    int lat, dn;
    lat = -1;
    dn  = 0;
    drive(1'b1, f, a, b, 1'b0);
    for (int k = 1; k <= 100; k++) begin
      idle();
      @(negedge clk);
      if (DoneE) begin
        dn++;
        if (lat < 0) lat = k;
      end
      if (!BusyE) break;
    end
    chk({nm, "_latency"}, lat, (FAST && is_mul(f)) ? 1 : W + 1);
    chk({nm, "_done_count"}, dn, 1);
    rd(F_MFHI, eh, {nm, "_hi"});
    rd(F_MFLO, el, {nm, "_lo"});
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dn;
    logic [5:0] fset [10];
    fset = '{F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU, 6'h20, 6'h1C};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rd(F_MFHI, '0, "reset_hi");
    rd(F_MFLO, '0, "reset_lo");

    run_op(F_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg2x3");
    run_op(F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf");
    run_op(F_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "divu_by0");
    run_op(F_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_neg_by0");
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, "multu_max");

    // MFLO held behind a multiply until the unit frees up.
    drive(1'b1, F_MULT, 32'd7, 32'd6, 1'b0);
    drive(1'b1, F_MFLO, '0, '0, 1'b0);
    @(negedge clk);
    chk("mflo_stalled_busy", {31'b0, BusyE}, 32'd1);
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, F_MFLO, '0, '0, 1'b0);
      @(negedge clk);
      if (!BusyE) break;
    end
    chk("mflo_after_mult", MdResultE, 32'd42);

    drive(1'b1, F_MTHI, 32'h1234, '0, 1'b0);
    rd(F_MFHI, 32'h1234, "mthi_mfhi");

    // Flush on the tenth RUN cycle of a divide.
    dn = 0;
    drive(1'b1, F_DIV, 32'd100, 32'd3, 1'b0);
    repeat (9) idle();
    drive(1'b0, 6'h0, '0, '0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      idle();
      @(negedge clk);
      if (k == 0) chk("cancel_idle_next", {31'b0, BusyE}, '0);
      if (DoneE) dn++;
    end
    chk("cancel_no_done", dn, 0);
    rd(F_MFHI, 32'h1234, "cancel_hi_kept");
    rd(F_MFLO, 32'd42, "cancel_lo_kept");

    // Flush on the write-back cycle itself.
    dn = 0;
    drive(1'b1, F_DIVU, 32'd9, 32'd2, 1'b0);
    repeat (W) idle();
    drive(1'b0, 6'h0, '0, '0, 1'b1);
    @(negedge clk);
    if (DoneE) dn++;
    chk("fix_cancel_no_done", dn, 0);
    rd(F_MFHI, 32'h1234, "fix_cancel_hi_kept");

    drive(1'b1, F_MULTU, 32'd3, 32'd3, 1'b1);
    idle();
    @(negedge clk);
    chk("idle_cancel_blocks", {31'b0, BusyE}, '0);

    // Async reset in the middle of a multiply.
    drive(1'b1, F_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    repeat (5) idle();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("reset_mid_busy", {31'b0, BusyE}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rd(F_MFHI, '0, "reset_mid_hi");
    rd(F_MFLO, '0, "reset_mid_lo");

    for (int i = 0; i < 400; i++) begin
      logic [5:0] f;
      f = fset[$urandom_range(0, 9)];
      drive(1'b1, f, pick_operand(), pick_operand(), ($urandom_range(0, 39) == 0));
      if ($urandom_range(0, 3) != 0) wait_idle();
      else repeat ($urandom_range(0, 3)) drive(1'b0, 6'h0, '0, '0, ($urandom_range(0, 15) == 0));
    end
    wait_idle();
    rd(F_MFHI, m_hi, "final_hi");
    rd(F_MFLO, m_lo, "final_lo");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
